// File: rtl/l1i_refill_engine.sv
// ============================================================================
// l1i_refill_engine : L1 I-cache line refill / single-word MMIO read engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module l1i_refill_engine #(
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
    parameter int          GUARD_CYCLES = 2
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         l1_mmu_req_read,
    input  logic [31:0]  l1_mmu_req_addr,
    output logic         mmu_l1_done,
    output logic [255:0] mmu_l1_read_data,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    localparam logic [2:0] c_guard_init  = 3'(GUARD_CYCLES);
    localparam logic [2:0] c_last_cached = 3'd7;

    state_t         r_state;
    logic [2:0]     r_word_cnt;
    logic [2:0]     r_guard_cnt;
    logic           r_is_mmio;
    logic [255:0]   r_line;

    logic           w_req_mmio;
    logic [31:0]    w_base;
    logic           w_last_word;
    logic           w_word_accept;
    logic [255:0]   w_line_next;

    assign w_req_mmio    = (l1_mmu_req_addr >= MMIO_BASE);
    assign w_base        = w_req_mmio ? {l1_mmu_req_addr[31:2], 2'b00}
                                      : {l1_mmu_req_addr[31:5], 5'b00000};
    assign w_last_word   = r_is_mmio || (r_word_cnt == c_last_cached);
    // rvalid only counts while a request is outstanding
    assign w_word_accept = mem_req && mem_rvalid;

    always_comb begin
        w_line_next = r_line;
        if (r_is_mmio) begin
            w_line_next = {224'd0, mem_rdata};
        end else begin
            w_line_next[{r_word_cnt, 5'b00000} +: 32] = mem_rdata;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_word_cnt       <= 3'd0;
            r_guard_cnt      <= 3'd0;
            r_is_mmio        <= 1'b0;
            r_line           <= 256'd0;
            mmu_l1_done      <= 1'b0;
            mmu_l1_read_data <= 256'd0;
            mem_req          <= 1'b0;
            mem_addr         <= 32'd0;
            busy             <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (l1_mmu_req_read) begin
                        r_is_mmio  <= w_req_mmio;
                        mem_addr   <= w_base;
                        mem_req    <= 1'b1;
                        r_word_cnt <= 3'd0;
                        busy       <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_word_accept) begin
                        r_line <= w_line_next;
                        if (w_last_word) begin
                            mem_req          <= 1'b0;
                            mmu_l1_done      <= 1'b1;
                            mmu_l1_read_data <= w_line_next;
                            r_state          <= S_DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 3'd1;
                            mem_addr   <= mem_addr + 32'd4;
                        end
                    end
                end
                S_DONE: begin
                    mmu_l1_done <= 1'b0;
                    r_guard_cnt <= c_guard_init;
                    r_state     <= S_GUARD;
                end
                S_GUARD: begin
                    // L1 still holds its request here while it writes the result
                    r_guard_cnt <= r_guard_cnt - 3'd1;
                    if (r_guard_cnt <= 3'd1) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
